// File: rtl/bram_tdp_clr_if.sv
// bram_tdp_clr_if: bus bundle for the dual-port clearable block RAM.
// Master drives requests and write data; slave (the RAM) returns read data and status.
interface bram_tdp_clr_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    localparam int BE_W = DATA_W / 8;

    logic              clr_req;
    logic              clr_busy;
    logic              ena;
    logic              enb;
    logic [BE_W-1:0]   wea;
    logic [BE_W-1:0]   web;
    logic [ADDR_W-1:0] addra;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dia;
    logic [DATA_W-1:0] dib;
    logic [DATA_W-1:0] doa;
    logic [DATA_W-1:0] dob;
    logic              doa_vld;
    logic              dob_vld;
    logic              coll;

    modport master (
        output clr_req, ena, enb, wea, web, addra, addrb, dia, dib,
        input  clr_busy, doa, dob, doa_vld, dob_vld, coll
    );

    modport slave (
        input  clr_req, ena, enb, wea, web, addra, addrb, dia, dib,
        output clr_busy, doa, dob, doa_vld, dob_vld, coll
    );
endinterface

// File: rtl/bram_tdp_clr.sv
// bram_tdp_clr: true dual-port block RAM with per-byte write enables, read-valid
// strobes, same-address collision reporting and a zero-fill clear engine.
// Optional macro BRAM_OUT_REG_EN adds one output register stage on both ports.
module bram_tdp_clr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          reset,
    bram_tdp_clr_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              acc_a, acc_b;
    logic [BE_W-1:0]   wr_a, wr_b;
    logic [DATA_W-1:0] new_a, new_b;
    logic              coll_d;

    logic [DATA_W-1:0] doa_q, dob_q;
    logic              vlda_q, vldb_q, coll_q;

    assign ready        = (state_q == StReady);
    assign bus.clr_busy = ~ready;
    assign acc_a        = ready & bus.ena;
    assign acc_b        = ready & bus.enb;
    assign wr_a         = acc_a ? bus.wea : '0;
    assign wr_b         = acc_b ? bus.web : '0;

    // Collision only matters when at least one side writes the shared word
    assign coll_d = acc_a & acc_b & (bus.addra == bus.addrb) & ((|wr_a) | (|wr_b));

    // Clear-engine next state; clr_req restarts the fill from address 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (bus.clr_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear-engine state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data: own-port write-first merge over the old word (read-first across ports)
    always_comb begin
        new_a = mem[bus.addra];
        new_b = mem[bus.addrb];
        for (int i = 0; i < BE_W; i++) begin
            if (wr_a[i]) new_a[8*i +: 8] = bus.dia[8*i +: 8];
            if (wr_b[i]) new_b[8*i +: 8] = bus.dib[8*i +: 8];
        end
    end

    // Array write; port A lanes are applied last so they win on shared lanes
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_b[i]) mem[bus.addrb][8*i +: 8] <= bus.dib[8*i +: 8];
            end
            for (int i = 0; i < BE_W; i++) begin
                if (wr_a[i]) mem[bus.addra][8*i +: 8] <= bus.dia[8*i +: 8];
            end
        end
    end

    // First output stage: data holds when the port is idle, strobes are single-cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            doa_q  <= '0;
            dob_q  <= '0;
            vlda_q <= 1'b0;
            vldb_q <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            vlda_q <= acc_a;
            vldb_q <= acc_b;
            coll_q <= coll_d;
            if (acc_a) doa_q <= new_a;
            if (acc_b) dob_q <= new_b;
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic [DATA_W-1:0] doa_q2, dob_q2;
    logic              vlda_q2, vldb_q2, coll_q2;

    // Extra output stage, delays data, strobes and collision flag together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            doa_q2  <= '0;
            dob_q2  <= '0;
            vlda_q2 <= 1'b0;
            vldb_q2 <= 1'b0;
            coll_q2 <= 1'b0;
        end else begin
            doa_q2  <= doa_q;
            dob_q2  <= dob_q;
            vlda_q2 <= vlda_q;
            vldb_q2 <= vldb_q;
            coll_q2 <= coll_q;
        end
    end

    assign bus.doa     = doa_q2;
    assign bus.dob     = dob_q2;
    assign bus.doa_vld = vlda_q2;
    assign bus.dob_vld = vldb_q2;
    assign bus.coll    = coll_q2;
`else
    assign bus.doa     = doa_q;
    assign bus.dob     = dob_q;
    assign bus.doa_vld = vlda_q;
    assign bus.dob_vld = vldb_q;
    assign bus.coll    = coll_q;
`endif
endmodule
